// File: rtl/pipelined_add_sub_unit_if.sv
// Operand/result handshake bundle for the pipelined add/sub unit.
// master drives operands and out_ready; slave is the arithmetic unit.
interface pipelined_add_sub_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, carry_in, op, out_ready,
    input  in_ready, out_valid, sum, carry_out,
    input  overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, carry_in, op, out_ready,
    output in_ready, out_valid, sum, carry_out,
    output overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_add_sub_unit.sv
// Slice-per-stage pipelined adder/subtractor with registered carries,
// ALU flags and a stall-the-whole-pipe valid/ready handshake.
module pipelined_add_sub_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_add_sub_unit_if.slave io
);
  localparam int SW = WIDTH / STAGES;

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t pipe [STAGES];
  logic   adv;
  logic   ov_q;
  logic   z_q;
  logic   n_q;

  assign adv         = !pipe[STAGES-1].v || io.out_ready;
  assign io.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t              s_in;
    logic [SW:0]         slice;
    logic [WIDTH+SW-1:0] r_cat;
    logic [WIDTH+SW-1:0] a_cat;
    logic [WIDTH+SW-1:0] b_cat;

    if (k == 0) begin : g_head
      assign s_in = '{
        v: io.in_valid,
        c: io.carry_in,
        r: '0,
        a: io.a,
        b: io.op ? ~io.b : io.b
      };
    end else begin : g_body
      assign s_in = pipe[k-1];
    end

    assign slice = {1'b0, s_in.a[SW-1:0]}
                 + {1'b0, s_in.b[SW-1:0]}
                 + {{SW{1'b0}}, s_in.c};

    // new slice enters at the top; after STAGES shifts slice 0 sits at bit 0
    assign r_cat = {slice[SW-1:0], s_in.r};
    assign a_cat = {{SW{1'b0}}, s_in.a};
    assign b_cat = {{SW{1'b0}}, s_in.b};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe[k] <= '0;
      end else if (adv) begin
        pipe[k].v <= s_in.v;
        pipe[k].c <= slice[SW];
        pipe[k].r <= r_cat[WIDTH+SW-1:SW];
        pipe[k].a <= a_cat[WIDTH+SW-1:SW];
        pipe[k].b <= b_cat[WIDTH+SW-1:SW];
      end
    end

    if (k == STAGES - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
          z_q  <= 1'b0;
          n_q  <= 1'b0;
        end else if (adv) begin
          ov_q <= (s_in.a[SW-1] == s_in.b[SW-1])
               && (slice[SW-1] != s_in.a[SW-1]);
          z_q  <= (r_cat[WIDTH+SW-1:SW] == '0);
          n_q  <= slice[SW-1];
        end
      end
    end
  end

  assign io.out_valid = pipe[STAGES-1].v;
  assign io.sum       = pipe[STAGES-1].r;
  assign io.carry_out = pipe[STAGES-1].c;
  assign io.overflow  = ov_q;
  assign io.zero      = z_q;
  assign io.negative  = n_q;
endmodule

// File: tb/tb_pipelined_add_sub_unit.sv
// Directed and streaming bench for pipelined_add_sub_unit in three
// width/depth configurations.
module tb_pipelined_add_sub_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_add_sub_unit_if #(.WIDTH(32)) i0 ();
  pipelined_add_sub_unit_if #(.WIDTH(8))  i1 ();
  pipelined_add_sub_unit_if #(.WIDTH(64)) i2 ();

  pipelined_add_sub_unit #(.WIDTH(32), .STAGES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .io(i0.slave));
  pipelined_add_sub_unit #(.WIDTH(8), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .io(i1.slave));
  pipelined_add_sub_unit #(.WIDTH(64), .STAGES(8)) u2 (
    .clk(clk), .rst_n(rst_n), .io(i2.slave));

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  fl;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  logic held = 1'b0;
  logic [31:0] held_sum;
  logic [3:0]  held_fl;
  int   n_in = 0;
  int   n_out = 0;

  int          lat0, lat1, lat2;
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [63:0] s2;
  logic [3:0]  f0, f1, f2;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic op);
    exp_t        e;
    logic [31:0] bp;
    logic [32:0] t;
    bp = op ? ~b : b;
    t = {1'b0, a} + {1'b0, bp} + {32'd0, ci};
    e.sum = t[31:0];
    e.fl = {t[32],
            (a[31] == bp[31]) && (t[31] != a[31]),
            t[31:0] == 32'd0,
            t[31]};
    return e;
  endfunction

  // one cycle on u0: drive at posedge+1, sample at negedge
  task automatic step(input logic iv, input logic ordy);
    logic [31:0] a, b;
    logic        ci, op;
    exp_t        e;
    a = $urandom; b = $urandom;
    ci = 1'($urandom_range(0, 1)); op = 1'($urandom_range(0, 1));
    i0.in_valid = iv; i0.a = a; i0.b = b;
    i0.carry_in = ci; i0.op = op; i0.out_ready = ordy;
    @(negedge clk);
    check("in_ready", i0.in_ready, !i0.out_valid || ordy);
    if (held) begin
      check("hold_valid", i0.out_valid, 1'b1);
      check("hold_sum", i0.sum, held_sum);
      check("hold_flags", {i0.carry_out, i0.overflow, i0.zero, i0.negative},
            held_fl);
      held = 1'b0;
    end
    if (i0.out_valid && ordy) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("stream_sum", i0.sum, e.sum);
        check("stream_flags",
              {i0.carry_out, i0.overflow, i0.zero, i0.negative}, e.fl);
      end
    end else if (i0.out_valid) begin
      held = 1'b1;
      held_sum = i0.sum;
      held_fl = {i0.carry_out, i0.overflow, i0.zero, i0.negative};
    end
    if (iv && i0.in_ready) begin
      q.push_back(model(a, b, ci, op));
      n_in++;
    end
    @(posedge clk); #1;
  endtask

  // one op into all three units at once; latency and outputs captured
  task automatic directed(input logic [31:0] a0, input logic [31:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1,
                          input logic [63:0] a2, input logic [63:0] b2,
                          input logic ci, input logic op);
    i0.in_valid = 1; i0.a = a0; i0.b = b0;
    i0.carry_in = ci; i0.op = op; i0.out_ready = 1;
    i1.in_valid = 1; i1.a = a1; i1.b = b1;
    i1.carry_in = ci; i1.op = op; i1.out_ready = 1;
    i2.in_valid = 1; i2.a = a2; i2.b = b2;
    i2.carry_in = ci; i2.op = op; i2.out_ready = 1;
    lat0 = 0; lat1 = 0; lat2 = 0;
    @(posedge clk); #1;
    i0.in_valid = 0; i1.in_valid = 0; i2.in_valid = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (lat0 == 0 && i0.out_valid) begin
        lat0 = cyc; s0 = i0.sum;
        f0 = {i0.carry_out, i0.overflow, i0.zero, i0.negative};
      end
      if (lat1 == 0 && i1.out_valid) begin
        lat1 = cyc; s1 = i1.sum;
        f1 = {i1.carry_out, i1.overflow, i1.zero, i1.negative};
      end
      if (lat2 == 0 && i2.out_valid) begin
        lat2 = cyc; s2 = i2.sum;
        f2 = {i2.carry_out, i2.overflow, i2.zero, i2.negative};
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i0.in_valid = 0; i0.a = 0; i0.b = 0; i0.carry_in = 0; i0.op = 0;
    i0.out_ready = 1;
    i1.in_valid = 0; i1.a = 0; i1.b = 0; i1.carry_in = 0; i1.op = 0;
    i1.out_ready = 1;
    i2.in_valid = 0; i2.a = 0; i2.b = 0; i2.carry_in = 0; i2.op = 0;
    i2.out_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid", i0.out_valid, 1'b0);
    check("rst_sum", i0.sum, 32'd0);
    check("rst_flags", {i0.carry_out, i0.overflow, i0.zero, i0.negative},
          4'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", i0.in_ready, 1'b1);

    directed(32'hFFFF_FFFF, 32'd1, 8'hFF, 8'd1, '1, 64'd1, 1'b0, 1'b0);
    check("add_lat32", lat0, 4);
    check("add_lat8", lat1, 1);
    check("add_lat64", lat2, 8);
    check("add_sum32", s0, 32'd0);
    check("add_fl32", f0, 4'b1010);
    check("add_sum8", s1, 8'd0);
    check("add_fl8", f1, 4'b1010);
    check("add_sum64", s2, 64'd0);
    check("add_fl64", f2, 4'b1010);

    directed(32'd5, 32'd7, 8'd5, 8'd7, 64'd5, 64'd7, 1'b1, 1'b1);
    check("sub_sum32", s0, 32'hFFFF_FFFE);
    check("sub_fl32", f0, 4'b0001);
    check("sub_sum8", s1, 8'hFE);
    check("sub_fl8", f1, 4'b0001);
    check("sub_sum64", s2, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_fl64", f2, 4'b0001);
    check("sub_lat64", lat2, 8);

    directed(32'h8000_0000, 32'd1, 8'h80, 8'd1,
             64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    check("ovf_sum32", s0, 32'h7FFF_FFFF);
    check("ovf_fl32", f0, 4'b1100);
    check("ovf_sum8", s1, 8'h7F);
    check("ovf_fl8", f1, 4'b1100);
    check("ovf_sum64", s2, 64'h7FFF_FFFF_FFFF_FFFF);
    check("ovf_fl64", f2, 4'b1100);

    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 250; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    check("drain_empty", q.size(), 0);
    check("in_out_count", n_out, n_in);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rst_n = 0;
    #2;
    check("midrst_valid", i0.out_valid, 1'b0);
    check("midrst_sum", i0.sum, 32'd0);
    check("midrst_flags",
          {i0.carry_out, i0.overflow, i0.zero, i0.negative}, 4'd0);
    q.delete();
    held = 1'b0;
    i0.in_valid = 0; i0.out_ready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    check("midrst_in_ready", i0.in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", i0.out_valid, 1'b0);
    end
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
